// File: rtl/t_ff_bank_if.sv
// t_ff_bank bus: control, data and status of a T flip-flop bank.
// Master drives En/Mode/T/D; slave returns Q/Q_bar/Changed/Tc.
interface t_ff_bank_if #(
  parameter int WIDTH = 8
);
  logic             En;
  logic [1:0]       Mode;
  logic [WIDTH-1:0] T;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Q_bar;
  logic             Changed;
  logic             Tc;

  modport master (
    output En,
    output Mode,
    output T,
    output D,
    input  Q,
    input  Q_bar,
    input  Changed,
    input  Tc
  );

  modport slave (
    input  En,
    input  Mode,
    input  T,
    input  D,
    output Q,
    output Q_bar,
    output Changed,
    output Tc
  );
endinterface

// File: rtl/t_ff_bank.sv
// WIDTH-bit bank of edge-triggered T flip-flops.
// Modes: toggle, up-count from T cells, parallel load, masked clear.
module t_ff_bank #(
  parameter int             WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic        clk,
  input logic        rst,
  t_ff_bank_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_TOGGLE = 2'b00,
    MODE_COUNT  = 2'b01,
    MODE_LOAD   = 2'b10,
    MODE_CLEAR  = 2'b11
  } mode_e;

  mode_e            mode;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] cnt_tog;
  logic             changed_q;
  logic             changed_d;

  assign mode = mode_e'(bus.Mode);

  // Count-mode T inputs: each cell toggles when all lower cells are 1
  always_comb begin
    cnt_tog    = '0;
    cnt_tog[0] = bus.T[0];
    for (int i = 1; i < WIDTH; i++) begin
      cnt_tog[i] = cnt_tog[i-1] & q_q[i-1];
    end
  end

  // Next state by mode; mode/T/D are only looked at when enabled
  always_comb begin
    q_d       = q_q;
    changed_d = 1'b0;
    if (bus.En) begin
      case (mode)
        MODE_TOGGLE: q_d = q_q ^ bus.T;
        MODE_COUNT:  q_d = q_q ^ cnt_tog;
        MODE_LOAD:   q_d = bus.D;
        MODE_CLEAR:  q_d = q_q & ~bus.T;
        default:     q_d = q_q;
      endcase
      changed_d = (q_d != q_q);
    end
  end

  // State register with synchronous reset taking priority
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q       <= RESET_VAL;
      changed_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      changed_q <= changed_d;
    end
  end

  assign bus.Q       = q_q;
  assign bus.Q_bar   = ~q_q;
  assign bus.Changed = changed_q;
  assign bus.Tc      = (mode == MODE_COUNT) & bus.En
                     & bus.T[0] & (&q_q);

endmodule

// File: tb/tb_t_ff_bank.sv
// Table-driven bench for t_ff_bank with an expected-result queue.
// Three instances: WIDTH=8/A5 reset, WIDTH=8/0 reset, WIDTH=1.
module tb_t_ff_bank;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  t_ff_bank_if #(.WIDTH(8)) bus_a ();
  t_ff_bank_if #(.WIDTH(8)) bus_b ();
  t_ff_bank_if #(.WIDTH(1)) bus_c ();

  t_ff_bank #(.WIDTH(8), .RESET_VAL(8'hA5)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  t_ff_bank #(.WIDTH(8), .RESET_VAL(8'h00)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  t_ff_bank #(.WIDTH(1), .RESET_VAL(1'b0)) dut_c (
    .clk (clk),
    .rst (rst),
    .bus (bus_c)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [7:0] t;
    logic [7:0] d;
    logic [7:0] q;
    logic       ch;
    logic       tc;
  } vec_t;

  typedef struct {
    int         dut;
    logic [7:0] q;
    logic       ch;
  } exp_t;

  localparam int NV = 29;

  vec_t vt [NV];
  exp_t sbq [$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s got %h want %h", nm, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic drive(input logic r, input logic e,
                       input logic [1:0] m, input logic [7:0] t,
                       input logic [7:0] d);
    @(negedge clk);
    rst        = r;
    bus_a.En   = e;
    bus_a.Mode = m;
    bus_a.T    = t;
    bus_a.D    = d;
    bus_b.En   = e;
    bus_b.Mode = m;
    bus_b.T    = t;
    bus_b.D    = d;
    bus_c.En   = e;
    bus_c.Mode = m;
    bus_c.T    = t[0];
    bus_c.D    = d[0];
    #1;
  endtask

  task automatic edge_drain(input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      case (e.dut)
        0: begin
          chk({nm, "_a_q"}, bus_a.Q, e.q);
          chk({nm, "_a_qb"}, bus_a.Q_bar, ~e.q);
          chk({nm, "_a_ch"}, {7'b0, bus_a.Changed}, {7'b0, e.ch});
        end
        1: begin
          chk({nm, "_b_q"}, bus_b.Q, e.q);
          chk({nm, "_b_ch"}, {7'b0, bus_b.Changed}, {7'b0, e.ch});
        end
        default: begin
          chk({nm, "_c_q"}, {7'b0, bus_c.Q}, {7'b0, e.q[0]});
          chk({nm, "_c_qb"}, {7'b0, bus_c.Q_bar}, {7'b0, ~e.q[0]});
          chk({nm, "_c_ch"}, {7'b0, bus_c.Changed}, {7'b0, e.ch});
        end
      endcase
    end
  endtask

  task automatic push(input int dut, input logic [7:0] q,
                      input logic ch);
    exp_t e;
    e.dut = dut;
    e.q   = q;
    e.ch  = ch;
    sbq.push_back(e);
  endtask

  initial begin
    //        rst   en    mode   t      d      q      ch    tc
    vt[0]  = '{1'b1, 1'b1, 2'd2, 8'h00, 8'hFF, 8'hA5, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 1'b1, 2'd2, 8'h00, 8'hFF, 8'hA5, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 2'd2, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 2'd0, 8'h0F, 8'h00, 8'h0F, 1'b1, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 2'd0, 8'h00, 8'h00, 8'h0F, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 2'd0, 8'hFF, 8'h00, 8'hF0, 1'b1, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 2'd2, 8'h00, 8'hFD, 8'hFD, 1'b1, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 2'd1, 8'h01, 8'h00, 8'hFE, 1'b1, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 2'd1, 8'h01, 8'h00, 8'hFF, 1'b1, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 2'd1, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1};
    vt[10] = '{1'b0, 1'b1, 2'd1, 8'hFE, 8'h00, 8'h00, 1'b0, 1'b0};
    vt[11] = '{1'b0, 1'b1, 2'd1, 8'hFF, 8'h00, 8'h01, 1'b1, 1'b0};
    vt[12] = '{1'b0, 1'b1, 2'd2, 8'h00, 8'h3C, 8'h3C, 1'b1, 1'b0};
    vt[13] = '{1'b0, 1'b0, 2'd0, 8'hFF, 8'h00, 8'h3C, 1'b0, 1'b0};
    vt[14] = '{1'b0, 1'b0, 2'd0, 8'hFF, 8'h00, 8'h3C, 1'b0, 1'b0};
    vt[15] = '{1'b0, 1'b0, 2'd0, 8'hFF, 8'h00, 8'h3C, 1'b0, 1'b0};
    vt[16] = '{1'b0, 1'b0, 2'd0, 8'hFF, 8'h00, 8'h3C, 1'b0, 1'b0};
    vt[17] = '{1'b0, 1'b1, 2'd0, 8'hFF, 8'h00, 8'hC3, 1'b1, 1'b0};
    vt[18] = '{1'b0, 1'b1, 2'd2, 8'h00, 8'hFF, 8'hFF, 1'b1, 1'b0};
    vt[19] = '{1'b0, 1'b1, 2'd3, 8'h81, 8'h00, 8'h7E, 1'b1, 1'b0};
    vt[20] = '{1'b0, 1'b1, 2'd2, 8'h00, 8'h7E, 8'h7E, 1'b0, 1'b0};
    vt[21] = '{1'b0, 1'b1, 2'd3, 8'h00, 8'h00, 8'h7E, 1'b0, 1'b0};
    vt[22] = '{1'b0, 1'b1, 2'd2, 8'h00, 8'hFF, 8'hFF, 1'b1, 1'b0};
    vt[23] = '{1'b0, 1'b0, 2'd1, 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};
    vt[24] = '{1'b0, 1'b1, 2'd0, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0};
    vt[25] = '{1'b0, 1'b1, 2'd1, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1};
    vt[26] = '{1'b0, 1'b0, 2'bxx, 8'hxx, 8'hxx, 8'h00, 1'b0, 1'b0};
    vt[27] = '{1'b1, 1'b0, 2'd1, 8'h01, 8'h00, 8'hA5, 1'b0, 1'b0};
    vt[28] = '{1'b0, 1'b1, 2'd1, 8'h01, 8'h00, 8'hA6, 1'b1, 1'b0};

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].rst, vt[i].en, vt[i].mode, vt[i].t, vt[i].d);
      chk($sformatf("v%0d_tc", i), {7'b0, bus_a.Tc}, {7'b0, vt[i].tc});
      push(0, vt[i].q, vt[i].ch);
      edge_drain($sformatf("v%0d", i));
    end

    // Reset mid-count on the zero-reset instance
    drive(1'b0, 1'b1, 2'd2, 8'h00, 8'h10);
    push(1, 8'h10, 1'b1);
    edge_drain("mc_load");
    drive(1'b0, 1'b1, 2'd1, 8'h01, 8'h00);
    push(1, 8'h11, 1'b1);
    edge_drain("mc_e1");
    drive(1'b0, 1'b1, 2'd1, 8'h01, 8'h00);
    push(1, 8'h12, 1'b1);
    edge_drain("mc_e2");
    drive(1'b1, 1'b1, 2'd1, 8'h01, 8'h00);
    push(1, 8'h00, 1'b0);
    edge_drain("mc_rst");
    drive(1'b0, 1'b1, 2'd1, 8'h01, 8'h00);
    push(1, 8'h01, 1'b1);
    edge_drain("mc_e4");
    drive(1'b0, 1'b1, 2'd1, 8'h01, 8'h00);
    push(1, 8'h02, 1'b1);
    edge_drain("mc_e5");

    // Single-cell bank: count behaves as toggle on bit 0
    drive(1'b1, 1'b1, 2'd2, 8'h00, 8'h00);
    push(2, 8'h00, 1'b0);
    edge_drain("w1_rst");
    drive(1'b0, 1'b1, 2'd1, 8'h01, 8'h00);
    chk("w1_tc0", {7'b0, bus_c.Tc}, 8'h00);
    push(2, 8'h01, 1'b1);
    edge_drain("w1_c1");
    drive(1'b0, 1'b1, 2'd1, 8'h01, 8'h00);
    chk("w1_tc1", {7'b0, bus_c.Tc}, 8'h01);
    push(2, 8'h00, 1'b1);
    edge_drain("w1_c2");
    drive(1'b0, 1'b1, 2'd0, 8'h01, 8'h00);
    chk("w1_tc2", {7'b0, bus_c.Tc}, 8'h00);
    push(2, 8'h01, 1'b1);
    edge_drain("w1_t1");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/t_ff_bank.md
Name: t_ff_bank

Overview:
- Parametrised, clocked successor to the single-bit T latch: a WIDTH-bit bank of edge-triggered T flip-flops with a shared enable and four operating modes.
- Modes: per-bit toggle, synchronous binary count built from T cells, parallel load, and masked clear.
- Provides Q and Q_bar buses, a registered change flag and a terminal-count flag.
- Serves as the general storage/counter primitive for the upcoming flip-flop and counter exercises.

Parameters:
- WIDTH, 8, number of T cells; legal range 1..32.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into Q on reset.

Ports:
- clk  input  1  rising-edge clock, only clock in the block
- rst  input  1  synchronous reset, active-high
- En  input  1  global enable; 0 = hold all state
- Mode  input  2  00 TOGGLE, 01 COUNT, 10 LOAD, 11 CLEAR
- T  input  WIDTH  per-bit toggle/clear mask; T[0] is the count enable in COUNT mode
- D  input  WIDTH  parallel load data
- Q  output  WIDTH  registered state
- Q_bar  output  WIDTH  bitwise complement of Q (combinational from Q)
- Changed  output  1  registered; high for the cycle after any edge where Q changed value
- Tc  output  1  terminal count (combinational)

Behaviour:
- Interface: one clock (clk). Reset (rst) is synchronous and active-high.
- All state updates occur on the rising edge of clk. There are no latches and no combinational feedback.
- Priority at each edge: rst > En=0 > Mode.
- rst=1: Q <= RESET_VAL and Changed <= 0, regardless of En, Mode, T or D.
- After reset: Q_bar = ~RESET_VAL and Tc = 0.
- En=0: Q holds and Changed <= 0.
- En=1, next-state next_Q by Mode:
  - TOGGLE (00): next_Q = Q ^ T. T=0 holds, T=1 inverts each bit independently.
  - COUNT (01): bit i toggles when T[0]=1 and Q[i-1:0] are all 1; bit 0 toggles when T[0]=1. This is an up-counter, modulo 2^WIDTH. All-ones wraps to all-zeros. T[WIDTH-1:1] are ignored in this mode.
  - LOAD (10): next_Q = D.
  - CLEAR (11): next_Q = Q & ~T, clearing masked bits. Bits are never set in this mode.
- Changed <= (next_Q != Q) when En=1. Changed is high in exactly the cycle in which the new Q is first visible.
- Tc = (Mode==01) & En & T[0] & (&Q). It is high in the cycle before the wrap, and is never asserted outside COUNT mode.
- Latency: 1 cycle from input to Q. 0 cycles from Q to Q_bar and Tc.
- Mode changes take effect on the same edge. No internal state other than Q and Changed exists, so no drain or flush is needed.
- A LOAD of the current value gives Changed=0. TOGGLE with T=0 gives Changed=0.
- Reset asserted mid-count: the next edge forces RESET_VAL and the count restarts from there. There is no partial update.
- WIDTH=1: COUNT mode is equivalent to TOGGLE on bit 0, and Tc = T[0] & Q & En & (Mode==01).
- X on T, D or Mode while En=0 or rst=1 must not propagate to Q.

Test Plan:
- Reset: WIDTH=8, RESET_VAL=8'hA5, hold rst=1 for 2 edges with En=1, Mode=10, D=8'hFF -> Q=8'hA5, Q_bar=8'h5A, Changed=0, Tc=0.
- TOGGLE: Q=8'h00, En=1, Mode=00, T=8'h0F for 1 edge -> Q=8'h0F, Changed=1. Next edge with T=8'h00 -> Q=8'h0F, Changed=0. Next edge with T=8'hFF -> Q=8'hF0.
- COUNT wrap: LOAD 8'hFD, then Mode=01, T=8'h01 for 3 edges -> Q sequence FE, FF, 00. Tc=1 only while Q=FF. Changed=1 each cycle.
- Enable hold: Q=8'h3C, En=0, Mode=00, T=8'hFF for 4 edges -> Q=8'h3C throughout, Changed=0. Raise En for 1 edge -> Q=8'hC3.
- CLEAR and LOAD: LOAD D=8'hFF -> Q=8'hFF. CLEAR with T=8'h81 -> Q=8'h7E. LOAD D=8'h7E -> Q=8'h7E, Changed=0.
- Reset mid-count: COUNT from 8'h10, assert rst on the 3rd edge -> Q goes 11, 12, then 00 (RESET_VAL=0). After release, counting resumes 01, 02.
